// File: rtl/dnn_pkg.sv
// Shared definitions for the dnn output stages: width defaults, FSM state type,
// and an index-width helper.
package dnn_pkg;

    localparam int DNN_DATA_WIDTH = 4;
    localparam int DNN_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_t;

    // Bits needed to index n entries, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dnn_out_argmax_if.sv
// Score-in / result-out handshake bundle of the argmax output stage.
interface dnn_out_argmax_if
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH = DNN_DATA_WIDTH,
    parameter int N_OUT      = 10,
    parameter int IDX_WIDTH  = DNN_ADDR_WIDTH
);
    logic                                 scores_valid;
    logic [N_OUT-1:0][DATA_WIDTH-1:0]     scores;
    logic                                 result_valid;
    logic                                 result_ready;
    logic [IDX_WIDTH-1:0]                 class_idx;
    logic [DATA_WIDTH-1:0]                class_score;

    modport master (
        output scores_valid, scores, result_ready,
        input  result_valid, class_idx, class_score
    );

    modport slave (
        input  scores_valid, scores, result_ready,
        output result_valid, class_idx, class_score
    );
endinterface

// File: rtl/dnn_score_bank.sv
// Snapshot register array with a registered random-access read port;
// out-of-range read indices return entry 0.
module dnn_score_bank
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH = DNN_DATA_WIDTH,
    parameter int N_OUT      = 10,
    parameter int IDX_WIDTH  = DNN_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clear,
    input  logic                             i_load,
    input  logic [N_OUT-1:0][DATA_WIDTH-1:0] i_scores,
    input  logic [IDX_WIDTH-1:0]             i_rd_idx,
    output logic [N_OUT-1:0][DATA_WIDTH-1:0] o_snapshot,
    output logic [DATA_WIDTH-1:0]            o_rd_data
);
    logic [N_OUT-1:0][DATA_WIDTH-1:0] r_snap;
    logic [DATA_WIDTH-1:0]            r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap    <= '0;
            r_rd_data <= '0;
        end else if (i_clear) begin
            r_snap    <= '0;
            r_rd_data <= '0;
        end else begin
            if (i_load) begin
                r_snap <= i_scores;
            end
            // Reads the pre-load snapshot in a load cycle.
            r_rd_data <= (int'(i_rd_idx) < N_OUT) ? r_snap[i_rd_idx] : r_snap[0];
        end
    end

    assign o_snapshot = r_snap;
    assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/dnn_out_argmax.sv
// Output stage: snapshots class scores, scans them one per cycle for the argmax,
// and offers the winning class over a valid/ready handshake.
module dnn_out_argmax
    import dnn_pkg::*;
#(
    parameter int DATA_WIDTH = DNN_DATA_WIDTH,
    parameter int N_OUT      = 10,
    parameter int IDX_WIDTH  = DNN_ADDR_WIDTH,
    parameter bit TIE_LOW    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    dnn_out_argmax_if.slave       bus,
    output logic                  o_busy,
    output logic                  o_overrun,
    input  logic [IDX_WIDTH-1:0]  i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    if (IDX_WIDTH < clog2_min1(N_OUT)) begin : g_idx_width_too_small
        $error("IDX_WIDTH too small for N_OUT");
    end

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(N_OUT - 1);

    state_t                           r_state;
    logic signed [DATA_WIDTH-1:0]     r_best_score;
    logic [IDX_WIDTH-1:0]             r_best_idx;
    logic [IDX_WIDTH-1:0]             r_cnt;
    logic                             r_busy;
    logic                             r_overrun;
    logic                             r_result_valid;
    logic [IDX_WIDTH-1:0]             r_class_idx;
    logic [DATA_WIDTH-1:0]            r_class_score;

    logic [N_OUT-1:0][DATA_WIDTH-1:0] w_snapshot;
    logic                             w_handshake;
    logic                             w_load;
    logic signed [DATA_WIDTH-1:0]     w_cand;
    logic                             w_take;
    logic signed [DATA_WIDTH-1:0]     w_next_score;
    logic [IDX_WIDTH-1:0]             w_next_idx;

    dnn_score_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_OUT      (N_OUT),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (i_clear),
        .i_load     (w_load),
        .i_scores   (bus.scores),
        .i_rd_idx   (i_rd_idx),
        .o_snapshot (w_snapshot),
        .o_rd_data  (o_rd_data)
    );

    assign w_handshake  = (r_state == StDone) && bus.result_ready;
    assign w_load       = bus.scores_valid && ((r_state == StIdle) || w_handshake);
    assign w_cand       = w_snapshot[r_cnt];
    assign w_take       = TIE_LOW ? (w_cand > r_best_score) : (w_cand >= r_best_score);
    assign w_next_score = w_take ? w_cand : r_best_score;
    assign w_next_idx   = w_take ? r_cnt : r_best_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_best_score   <= '0;
            r_best_idx     <= '0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_result_valid <= 1'b0;
            r_class_idx    <= '0;
            r_class_score  <= '0;
        end else if (i_clear) begin
            r_state        <= StIdle;
            r_best_score   <= '0;
            r_best_idx     <= '0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_result_valid <= 1'b0;
            r_class_idx    <= '0;
            r_class_score  <= '0;
        end else begin
            if (bus.scores_valid && !w_load) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                StIdle: ;
                StScan: begin
                    r_best_score <= w_next_score;
                    r_best_idx   <= w_next_idx;
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == LastIdx) begin
                        r_state        <= StDone;
                        r_result_valid <= 1'b1;
                        r_class_idx    <= w_next_idx;
                        r_class_score  <= w_next_score;
                    end
                end
                StDone: begin
                    if (w_handshake) begin
                        r_state        <= StIdle;
                        r_busy         <= 1'b0;
                        r_result_valid <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // A load overrides the handshake's return to idle (back-to-back case).
            if (w_load) begin
                r_best_score <= bus.scores[0];
                r_best_idx   <= '0;
                r_cnt        <= IDX_WIDTH'(1);
                r_busy       <= 1'b1;
                if (N_OUT == 1) begin
                    r_state        <= StDone;
                    r_result_valid <= 1'b1;
                    r_class_idx    <= '0;
                    r_class_score  <= bus.scores[0];
                end else begin
                    r_state <= StScan;
                end
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_overrun        = r_overrun;
    assign bus.result_valid = r_result_valid;
    assign bus.class_idx    = r_class_idx;
    assign bus.class_score  = r_class_score;

endmodule

// File: tb/tb_dnn_out_argmax.sv
// Self-checking bench for dnn_out_argmax: transaction-level reference model plus
// directed and randomized stimulus.
module tb_dnn_out_argmax;

    localparam int DW = 4;
    localparam int N  = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear;
    logic          clear1;
    logic [IW-1:0] rd_idx;
    logic [0:0]    rd_idx1;
    logic          busy_m, ovr_m, busy_t, ovr_t, busy1, ovr1;
    logic [DW-1:0] rd_m, rd_t;
    logic [7:0]    rd1;

    int n_checks = 0;
    int n_errors = 0;

    dnn_out_argmax_if #(.DATA_WIDTH(DW), .N_OUT(N), .IDX_WIDTH(IW)) if_m ();
    dnn_out_argmax_if #(.DATA_WIDTH(DW), .N_OUT(N), .IDX_WIDTH(IW)) if_t ();
    dnn_out_argmax_if #(.DATA_WIDTH(8), .N_OUT(1), .IDX_WIDTH(1))   if1 ();

    assign if_t.scores_valid = if_m.scores_valid;
    assign if_t.scores       = if_m.scores;
    assign if_t.result_ready = if_m.result_ready;

    dnn_out_argmax #(.DATA_WIDTH(DW), .N_OUT(N), .IDX_WIDTH(IW), .TIE_LOW(1'b1)) u_dut (
        .clk(clk), .rst(rst), .i_clear(clear), .bus(if_m),
        .o_busy(busy_m), .o_overrun(ovr_m), .i_rd_idx(rd_idx), .o_rd_data(rd_m)
    );

    dnn_out_argmax #(.DATA_WIDTH(DW), .N_OUT(N), .IDX_WIDTH(IW), .TIE_LOW(1'b0)) u_dut_t0 (
        .clk(clk), .rst(rst), .i_clear(clear), .bus(if_t),
        .o_busy(busy_t), .o_overrun(ovr_t), .i_rd_idx(rd_idx), .o_rd_data(rd_t)
    );

    dnn_out_argmax #(.DATA_WIDTH(8), .N_OUT(1), .IDX_WIDTH(1), .TIE_LOW(1'b1)) u_dut_n1 (
        .clk(clk), .rst(rst), .i_clear(clear1), .bus(if1),
        .o_busy(busy1), .o_overrun(ovr1), .i_rd_idx(rd_idx1), .o_rd_data(rd1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Max value first, then the lowest or highest index holding it.
    function automatic int argmax_of(input int a[N], input bit tie_low);
        int mx;
        int idx;
        mx = a[0];
        for (int i = 1; i < N; i++) if (a[i] > mx) mx = a[i];
        idx = -1;
        for (int i = 0; i < N; i++) begin
            if (a[i] == mx && (!tie_low || idx < 0)) idx = i;
        end
        return idx;
    endfunction

    // Reference model: phase 0 idle, 1 scanning, 2 result offered.
    int m_snap[N];
    int m_phase = 0;
    int m_left = 0;
    int m_exp_idx = 0, m_exp_idx_t0 = 0, m_exp_score = 0;
    int m_cls_idx = 0, m_cls_idx_t0 = 0, m_cls_score = 0;
    int m_ovr = 0;
    int m_rd = 0;

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            for (int i = 0; i < N; i++) m_snap[i] = 0;
            m_phase = 0; m_left = 0; m_ovr = 0; m_rd = 0;
            m_exp_idx = 0; m_exp_idx_t0 = 0; m_exp_score = 0;
            m_cls_idx = 0; m_cls_idx_t0 = 0; m_cls_score = 0;
        end else begin
            bit hs;
            bit acc;
            hs  = (m_phase == 2) && if_m.result_ready;
            acc = if_m.scores_valid && (m_phase == 0 || hs);
            if (if_m.scores_valid && !acc) m_ovr = 1;
            m_rd = (int'(rd_idx) < N) ? m_snap[rd_idx] : m_snap[0];
            if (hs) m_phase = 0;
            if (acc) begin
                for (int i = 0; i < N; i++) m_snap[i] = int'($signed(if_m.scores[i]));
                m_exp_idx    = argmax_of(m_snap, 1'b1);
                m_exp_idx_t0 = argmax_of(m_snap, 1'b0);
                m_exp_score  = m_snap[m_exp_idx];
                m_left       = N - 1;
                m_phase      = 1;
            end else if (m_phase == 1) begin
                m_left--;
            end
            if (m_phase == 1 && m_left == 0) begin
                m_phase      = 2;
                m_cls_idx    = m_exp_idx;
                m_cls_idx_t0 = m_exp_idx_t0;
                m_cls_score  = m_exp_score;
            end
        end
    end

    always @(negedge clk) begin
        check("m_busy",   int'(busy_m), (m_phase != 0) ? 1 : 0);
        check("m_ovr",    int'(ovr_m), m_ovr);
        check("m_valid",  int'(if_m.result_valid), (m_phase == 2) ? 1 : 0);
        check("m_idx",    int'(if_m.class_idx), m_cls_idx);
        check("m_score",  int'($signed(if_m.class_score)), m_cls_score);
        check("m_rd",     int'($signed(rd_m)), m_rd);
        check("t0_busy",  int'(busy_t), (m_phase != 0) ? 1 : 0);
        check("t0_ovr",   int'(ovr_t), m_ovr);
        check("t0_valid", int'(if_t.result_valid), (m_phase == 2) ? 1 : 0);
        check("t0_idx",   int'(if_t.class_idx), m_cls_idx_t0);
        check("t0_score", int'($signed(if_t.class_score)), m_cls_score);
        check("t0_rd",    int'($signed(rd_t)), m_rd);
    end

    int ta[N] = '{1, -3, 5, 2, 7, 0, -8, 7, 3, 4};
    int tb8[N] = '{-8, -8, -8, -8, -8, -8, -8, -8, -8, -8};
    int tc[N] = '{0, 1, 5, -2, 3, 0, -7, 4, 2, 6};

    task automatic pulse(input int v[N]);
        @(negedge clk);
        for (int i = 0; i < N; i++) if_m.scores[i] = DW'(v[i]);
        if_m.scores_valid = 1'b1;
        @(negedge clk);
        if_m.scores_valid = 1'b0;
    endtask

    initial begin
        if_m.scores_valid = 1'b0;
        if_m.scores       = '0;
        if_m.result_ready = 1'b0;
        if1.scores_valid  = 1'b0;
        if1.scores        = '0;
        if1.result_ready  = 1'b0;
        clear   = 1'b0;
        clear1  = 1'b0;
        rd_idx  = '0;
        rd_idx1 = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy",  int'(busy_m), 0);
        check("rst_ovr",   int'(ovr_m), 0);
        check("rst_valid", int'(if_m.result_valid), 0);
        check("rst_idx",   int'(if_m.class_idx), 0);
        check("rst_rd",    int'(rd_m), 0);
        rst = 1'b0;

        // Argmax with a tie at indices 4 and 7.
        pulse(ta);
        repeat (8) @(negedge clk);
        check("lat_early_valid", int'(if_m.result_valid), 0);
        @(negedge clk);
        check("lat_valid",   int'(if_m.result_valid), 1);
        check("a_idx",       int'(if_m.class_idx), 4);
        check("a_score",     int'($signed(if_m.class_score)), 7);
        check("a_idx_tie0",  int'(if_t.class_idx), 7);
        check("model_a_idx", m_exp_idx, 4);
        rd_idx = 4'd3;
        @(negedge clk);
        check("rd_idx3", int'($signed(rd_m)), 2);
        rd_idx = 4'd12;
        @(negedge clk);
        check("rd_idx12", int'($signed(rd_m)), 1);
        repeat (3) @(negedge clk);
        check("hold_valid", int'(if_m.result_valid), 1);
        check("hold_idx",   int'(if_m.class_idx), 4);
        if_m.result_ready = 1'b1;
        @(negedge clk);
        if_m.result_ready = 1'b0;
        check("hs_busy",  int'(busy_m), 0);
        check("hs_valid", int'(if_m.result_valid), 0);

        // All-negative scores with an overrun pulse mid-scan.
        pulse(tb8);
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) if_m.scores[i] = DW'(ta[i]);
        if_m.scores_valid = 1'b1;
        @(negedge clk);
        if_m.scores_valid = 1'b0;
        check("ovr_set", int'(ovr_m), 1);
        repeat (6) @(negedge clk);
        check("b_valid",     int'(if_m.result_valid), 1);
        check("b_idx",       int'(if_m.class_idx), 0);
        check("b_score",     int'($signed(if_m.class_score)), -8);
        check("b_idx_tie0",  int'(if_t.class_idx), 9);
        clear  = 1'b1;
        rd_idx = 4'd3;
        @(negedge clk);
        clear = 1'b0;
        check("clr_ovr",   int'(ovr_m), 0);
        check("clr_valid", int'(if_m.result_valid), 0);
        check("clr_rd",    int'(rd_m), 0);

        // Back-to-back: handshake and reload in the same cycle.
        pulse(ta);
        repeat (9) @(negedge clk);
        if_m.result_ready = 1'b1;
        for (int i = 0; i < N; i++) if_m.scores[i] = DW'(tc[i]);
        if_m.scores_valid = 1'b1;
        @(negedge clk);
        if_m.result_ready = 1'b0;
        if_m.scores_valid = 1'b0;
        check("b2b_valid_low", int'(if_m.result_valid), 0);
        check("b2b_busy",      int'(busy_m), 1);
        check("b2b_ovr",       int'(ovr_m), 0);
        repeat (8) @(negedge clk);
        check("b2b_early", int'(if_m.result_valid), 0);
        @(negedge clk);
        check("b2b_valid", int'(if_m.result_valid), 1);
        check("b2b_idx",   int'(if_m.class_idx), 9);
        if_m.result_ready = 1'b1;
        @(negedge clk);
        if_m.result_ready = 1'b0;

        // Random traffic against the model.
        repeat (500) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if_m.scores[i] = DW'($urandom_range(0, 15));
            if_m.scores_valid = ($urandom_range(0, 3) == 0);
            if_m.result_ready = ($urandom_range(0, 1) == 1);
            rd_idx            = IW'($urandom_range(0, 15));
            clear             = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        if_m.scores_valid = 1'b0;
        if_m.result_ready = 1'b0;
        clear             = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a scan.
        pulse(ta);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",  int'(busy_m), 0);
        check("arst_valid", int'(if_m.result_valid), 0);
        check("arst_idx",   int'(if_m.class_idx), 0);
        check("arst_score", int'(if_m.class_score), 0);
        check("arst_rd",    int'(rd_m), 0);
        check("arst_ovr",   int'(ovr_m), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single-class instance.
        check("n1_idle_valid", int'(if1.result_valid), 0);
        if1.scores[0]    = 8'(-100);
        if1.scores_valid = 1'b1;
        @(negedge clk);
        if1.scores_valid = 1'b0;
        check("n1_valid", int'(if1.result_valid), 1);
        check("n1_idx",   int'(if1.class_idx), 0);
        check("n1_score", int'($signed(if1.class_score)), -100);
        check("n1_busy",  int'(busy1), 1);
        rd_idx1 = 1'b0;
        @(negedge clk);
        check("n1_rd0", int'($signed(rd1)), -100);
        rd_idx1 = 1'b1;
        @(negedge clk);
        check("n1_rd_oob", int'($signed(rd1)), -100);
        if1.result_ready = 1'b1;
        @(negedge clk);
        if1.result_ready = 1'b0;
        check("n1_hs_valid", int'(if1.result_valid), 0);
        check("n1_hs_busy",  int'(busy1), 0);
        check("n1_ovr",      int'(ovr1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
